// File: rtl/fpu_addsub_ctrl.sv
// fpu_addsub_ctrl: issue/return controller for a fixed-latency FP subtractor.
// Add requests become subtractions by flipping the sign of operand 2. A
// valid/tag shift pipeline follows each request through the unit. A small
// response FIFO holds results until the consumer takes them. A credit rule
// (FIFO entries plus in-flight requests) makes sure the FIFO never overflows.
module fpu_addsub_ctrl #(
   parameter int LAT   = 3,   // clocks from unit_op* update to unit_result update
   parameter int DEPTH = 4,   // response FIFO entries == total credits
   parameter int TAG_W = 5    // request tag width
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_sub,
   input  logic [31:0]      req_op1,
   input  logic [31:0]      req_op2,
   input  logic [TAG_W-1:0] req_tag,
   output logic [31:0]      unit_op1,
   output logic [31:0]      unit_op2,
   input  logic [31:0]      unit_result,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_result,
   output logic [TAG_W-1:0] rsp_tag,
   output logic [2:0]       occupancy
);

   // The pipeline has one stage per unit clock, plus one stage for the capture edge.
   localparam int STAGES = LAT + 1;
   localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W  = $clog2(DEPTH + 1);

   localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef struct packed {
      logic [31:0]      result;
      logic [TAG_W-1:0] tag;
   } entry_t;

   // In-flight tracking
   logic [STAGES-1:0] pipe_vld_q, pipe_vld_d;
   logic [TAG_W-1:0]  pipe_tag_q [STAGES];
   logic [TAG_W-1:0]  pipe_tag_d [STAGES];

   // Registered operands to the unit
   logic [31:0] unit_op1_q, unit_op1_d;
   logic [31:0] unit_op2_q, unit_op2_d;

   // Response FIFO
   entry_t           mem_q [DEPTH];
   entry_t           mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] fifo_count_q, fifo_count_d;

   // Handshake events and credit accounting
   logic             accept;
   logic             push;
   logic             pop;
   logic [CNT_W-1:0] inflight;
   logic [CNT_W-1:0] occ_sum;

   // Advance a FIFO pointer, wrapping after the last entry.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_LAST) begin
         return '0;
      end
      return p + PTR_W'(1);
   endfunction

   // Credit count from registered state only, so a pop in this cycle frees no credit until the next edge.
   always_comb begin
      // NOTE: each always_comb output gets a default before any condition, so no path leaves it unassigned and infers a latch.
      inflight = '0;
      for (int i = 0; i < STAGES; i++) begin
         inflight = inflight + CNT_W'(pipe_vld_q[i]);
      end
      occ_sum   = fifo_count_q + inflight;
      req_ready = !reset && (occ_sum < CNT_DEPTH);
   end

   assign accept    = req_valid & req_ready;
   assign push      = pipe_vld_q[STAGES-1];
   assign rsp_valid = (fifo_count_q != '0);
   assign pop       = rsp_valid & rsp_ready;

   // Operand capture: turn add into subtract by flipping only the sign bit, and send zeros as a bubble.
   always_comb begin
      unit_op1_d = '0;
      unit_op2_d = '0;
      if (accept) begin
         unit_op1_d = req_op1;
         unit_op2_d = req_sub ? req_op2 : {~req_op2[31], req_op2[30:0]};
      end
   end

   // Valid/tag shift pipeline that matches the unit's fixed latency and never stalls.
   always_comb begin
      pipe_vld_d = '0;
      for (int i = 0; i < STAGES; i++) begin
         pipe_tag_d[i] = '0;
      end
      pipe_vld_d[0] = accept;
      pipe_tag_d[0] = accept ? req_tag : '0;
      for (int i = 1; i < STAGES; i++) begin
         pipe_vld_d[i] = pipe_vld_q[i-1];
         pipe_tag_d[i] = pipe_tag_q[i-1];
      end
   end

   // FIFO bookkeeping: write the tail on push, advance the head on pop, and keep the count when both happen.
   always_comb begin
      mem_d        = mem_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      fifo_count_d = fifo_count_q;
      if (push) begin
         mem_d[wr_ptr_q] = '{result: unit_result, tag: pipe_tag_q[STAGES-1]};
         wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      unique case ({push, pop})
         2'b10:   fifo_count_d = fifo_count_q + CNT_ONE;
         2'b01:   fifo_count_d = fifo_count_q - CNT_ONE;
         default: fifo_count_d = fifo_count_q;
      endcase
   end

   // Control state register. Reset wins over any accept or pop at the same edge.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values, whatever the statement order.
      if (reset) begin
         pipe_vld_q <= '0;
         for (int i = 0; i < STAGES; i++) begin
            pipe_tag_q[i] <= '0;
         end
         unit_op1_q   <= '0;
         unit_op2_q   <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         fifo_count_q <= '0;
      end else begin
         pipe_vld_q <= pipe_vld_d;
         for (int i = 0; i < STAGES; i++) begin
            pipe_tag_q[i] <= pipe_tag_d[i];
         end
         unit_op1_q   <= unit_op1_d;
         unit_op2_q   <= unit_op2_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         fifo_count_q <= fifo_count_d;
      end
   end

   // FIFO storage register.
   always_ff @(posedge clk) begin
      // NOTE: the storage array has no reset; fifo_count_q gates every read, so stale entries are never seen and plain RAM can be used.
      mem_q <= mem_d;
   end

   assign unit_op1   = unit_op1_q;
   assign unit_op2   = unit_op2_q;
   assign rsp_result = mem_q[rd_ptr_q].result;
   assign rsp_tag    = mem_q[rd_ptr_q].tag;
   assign occupancy  = 3'(occ_sum);

endmodule
